// File: rtl/neuron_lut_rr_scheduler.sv
// rtl/neuron_lut_rr_scheduler.sv - round-robin sharing of one neuron LUT among NUM_REQ requesters
// Optional macro NEURON_LUT_OUT_REG_EN adds a register stage after lut_data (latency 3 instead of 2).
module neuron_lut_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 2,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_addr,
  output logic [IN_W-1:0]         lut_addr,
  input  logic [OUT_W-1:0]        lut_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic             gnt_en;
  logic             s1_valid;
  logic [IN_W-1:0]  s1_addr;
  logic [ID_W-1:0]  s1_id;
  logic             s1_load;
  logic             out_adv;
  logic             src_valid;
  logic [OUT_W-1:0] src_data;
  logic [ID_W-1:0]  src_id;

  assign out_adv  = !rsp_valid || rsp_ready;
  assign lut_addr = s1_addr;

`ifdef NEURON_LUT_OUT_REG_EN
  logic             s2_valid;
  logic [OUT_W-1:0] s2_data;
  logic [ID_W-1:0]  s2_id;
  logic             s2_load;

  assign s2_load   = !s2_valid || out_adv;
  assign s1_load   = !s1_valid || s2_load;
  assign src_valid = s2_valid;
  assign src_data  = s2_data;
  assign src_id    = s2_id;
  assign busy      = s1_valid || s2_valid || rsp_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= lut_data;
        s2_id   <= s1_id;
      end
    end
  end
`else
  assign s1_load   = !s1_valid || out_adv;
  assign src_valid = s1_valid;
  assign src_data  = lut_data;
  assign src_id    = s1_id;
  assign busy      = s1_valid || rsp_valid;
`endif

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
    gnt_en    = gnt_any && s1_load && rst_n;
    req_ready = '0;
    if (gnt_en) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_id    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= gnt_en;
      end
      if (gnt_en) begin
        s1_addr <= req_addr[int'(gnt_id)*IN_W +: IN_W];
        s1_id   <= gnt_id;
        ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (out_adv) begin
      rsp_valid <= src_valid;
      if (src_valid) begin
        rsp_data <= src_data;
        rsp_id   <= src_id;
      end
    end
  end

endmodule

// File: tb/tb_neuron_lut_rr_scheduler.sv
// tb/tb_neuron_lut_rr_scheduler.sv - randomized bench for neuron_lut_rr_scheduler against a queue-based model
module tb_neuron_lut_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int IN_W    = 8;
  localparam int OUT_W   = 2;
  localparam int ID_W    = 2;
`ifdef NEURON_LUT_OUT_REG_EN
  localparam int LAT   = 3;
  localparam int DEPTH = 3;
`else
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*IN_W-1:0] req_addr;
  logic [IN_W-1:0]         lut_addr;
  logic [OUT_W-1:0]        lut_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [OUT_W-1:0]        rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic                    busy;

  logic [OUT_W-1:0] lut_mem [256];

  always #5 clk = ~clk;
  assign lut_data = lut_mem[lut_addr];

  neuron_lut_rr_scheduler #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .lut_addr(lut_addr), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  typedef struct {
    int id;
    int addr;
    int due;
  } ent_t;

  ent_t q[$];
  int   m_ptr, m_last, cyc;
  bit   rst_seen;
  bit   pend [NUM_REQ];
  int   paddr [NUM_REQ];
  int   n_cmp, n_bad;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requests in flight behave like a FIFO of DEPTH entries that may accept while popping.
  function automatic int exp_grant();
    int idx;
    if (!rst_n) return -1;
    if (!(q.size() < DEPTH || rsp_ready)) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                = pend[i];
      req_addr[i*IN_W +: IN_W]    = IN_W'(paddr[i]);
    end
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i] && ($urandom_range(0, 99) < pct)) begin
        pend[i]  = 1'b1;
        paddr[i] = $urandom_range(0, 255);
      end
    end
  endtask

  task automatic cycle();
    int g;
    bit exp_rv;
    bit pop;
    @(negedge clk);
    g      = exp_grant();
    exp_rv = (q.size() > 0) && (cyc >= q[0].due);
    if (rst_seen) begin
      check("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
      check("rsp_valid", int'(rsp_valid), int'(exp_rv));
      check("busy", int'(busy), int'(q.size() > 0));
      check("lut_addr", int'(lut_addr), m_last);
      if (exp_rv) begin
        check("rsp_data", int'(rsp_data), int'(lut_mem[q[0].addr]));
        check("rsp_id", int'(rsp_id), q[0].id);
      end
    end
    pop = exp_rv && rsp_ready;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_ptr    = 0;
      m_last   = 0;
      rst_seen = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, paddr[g], cyc + LAT});
        m_ptr   = (g + 1) % NUM_REQ;
        m_last  = paddr[g];
        pend[g] = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n, input int req_pct, input int rdy_pct);
    repeat (n) begin
      rsp_ready = ($urandom_range(0, 99) < rdy_pct);
      refill(req_pct);
      apply();
      cycle();
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; rst_seen = 1'b0;
    m_ptr = 0; m_last = 0;
    for (int i = 0; i < 256; i++) lut_mem[i] = OUT_W'($urandom);
    lut_mem[8'hA5] = 2'b10;
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0; req_addr = '0;

    // reset with every requester asking
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 1'b1; paddr[i] = $urandom_range(0, 255); end
    rsp_ready = 1'b1;
    repeat (3) begin apply(); cycle(); end
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_busy", int'(busy), 0);

    // single request from requester 2 at 8'hA5
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    pend[2] = 1'b1; paddr[2] = 8'hA5;
    apply(); cycle();
    check("single_lut_addr", int'(lut_addr), 8'hA5);
    run(LAT + 2, 0, 100);

    // wrap/skip: ptr is now 3
    pend[1] = 1'b1; paddr[1] = $urandom_range(0, 255);
    apply(); cycle();
    pend[0] = 1'b1; paddr[0] = $urandom_range(0, 255);
    pend[3] = 1'b1; paddr[3] = $urandom_range(0, 255);
    apply(); cycle();
    run(LAT + 4, 0, 100);

    // fairness under full load
    run(12, 100, 100);
    // backpressure under full load, then release
    run(5, 100, 0);
    run(10, 100, 100);
    run(LAT + 4, 0, 100);

    // reset with two entries in flight
    run(2, 100, 0);
    rst_n = 1'b0; apply(); cycle();
    rst_n = 1'b1;
    run(8, 100, 100);

    // random traffic with occasional resets
    repeat (3000) begin
      rst_n = ($urandom_range(0, 199) != 0);
      run(1, $urandom_range(0, 100), $urandom_range(0, 100));
    end
    rst_n = 1'b1;
    run(LAT + 4, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
